// File: rtl/mem_bus_arbiter.sv
// Arbitrates the fetch and load/store requesters onto one memory bus port,
// handling word alignment, byte lanes, load extension and a bounded ready wait.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [31:0] ls_addr,
  input  logic [1:0]  ls_size,
  input  logic        ls_unsigned,
  input  logic [31:0] ls_wdata,
  output logic        ls_done,
  output logic [31:0] ls_rdata,
  output logic        ls_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state_reg;
  logic        owner_ls_reg;
  logic [1:0]  offset_reg;
  logic [1:0]  size_reg;
  logic        unsigned_reg;
  logic [7:0]  cnt_reg;

  logic        ls_misaligned;
  logic        if_misaligned;
  logic [3:0]  ls_be;
  logic [31:0] ls_wdata_rep;
  logic [31:0] shifted;
  logic [31:0] load_data;
  logic        access_end;

  assign ls_misaligned = (ls_size == 2'b11) ||
                         (ls_size == 2'b10 && ls_addr[1:0] != 2'b00) ||
                         (ls_size == 2'b01 && ls_addr[0]);
  assign if_misaligned = (if_addr[1:0] != 2'b00);

  always_comb begin
    ls_be = 4'hF;
    case (ls_size)
      2'b00:   ls_be = 4'b0001 << ls_addr[1:0];
      2'b01:   ls_be = 4'b0011 << {ls_addr[1], 1'b0};
      default: ls_be = 4'hF;
    endcase
  end

  // Each byte lane picks the store byte that lands on it for the access size.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign ls_wdata_rep[8*gi +: 8] =
        (ls_size == 2'b00) ? ls_wdata[7:0] :
        (ls_size == 2'b01) ? ls_wdata[8*(gi%2) +: 8] :
                             ls_wdata[8*gi +: 8];
    end
  endgenerate

  assign shifted = mem_rdata >> {offset_reg, 3'b000};

  always_comb begin
    load_data = shifted;
    case (size_reg)
      2'b00:   load_data = unsigned_reg ? {24'h0, shifted[7:0]}
                                        : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_data = unsigned_reg ? {16'h0, shifted[15:0]}
                                        : {{16{shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  // Either the memory answered or the wait budget is used up this cycle.
  assign access_end = mem_ready || (cnt_reg == 8'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      owner_ls_reg <= 1'b0;
      offset_reg   <= 2'b00;
      size_reg     <= 2'b00;
      unsigned_reg <= 1'b0;
      cnt_reg      <= 8'd0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= 32'h0;
      mem_be       <= 4'h0;
      mem_wdata    <= 32'h0;
      if_done      <= 1'b0;
      if_rdata     <= 32'h0;
      if_err       <= 1'b0;
      ls_done      <= 1'b0;
      ls_rdata     <= 32'h0;
      ls_err       <= 1'b0;
    end else begin
      if_done <= 1'b0;
      ls_done <= 1'b0;
      case (state_reg)
        IDLE: begin
          cnt_reg <= 8'd0;
          if (ls_req) begin
            owner_ls_reg <= 1'b1;
            offset_reg   <= ls_addr[1:0];
            size_reg     <= ls_size;
            unsigned_reg <= ls_unsigned;
            if (ls_misaligned) begin
              state_reg <= RESP;
              ls_done   <= 1'b1;
              ls_err    <= 1'b1;
              ls_rdata  <= 32'h0;
            end else begin
              state_reg <= ACCESS;
              mem_req   <= 1'b1;
              mem_we    <= ls_we;
              mem_addr  <= {ls_addr[31:2], 2'b00};
              mem_be    <= ls_be;
              mem_wdata <= ls_wdata_rep;
            end
          end else if (if_req) begin
            owner_ls_reg <= 1'b0;
            offset_reg   <= 2'b00;
            size_reg     <= 2'b10;
            unsigned_reg <= 1'b0;
            if (if_misaligned) begin
              state_reg <= RESP;
              if_done   <= 1'b1;
              if_err    <= 1'b1;
              if_rdata  <= 32'h0;
            end else begin
              state_reg <= ACCESS;
              mem_req   <= 1'b1;
              mem_we    <= 1'b0;
              mem_addr  <= {if_addr[31:2], 2'b00};
              mem_be    <= 4'hF;
              mem_wdata <= 32'h0;
            end
          end
        end
        ACCESS: begin
          if (!mem_ready) cnt_reg <= cnt_reg + 8'd1;
          if (access_end) begin
            state_reg <= RESP;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_be    <= 4'h0;
            mem_wdata <= 32'h0;
            if (owner_ls_reg) begin
              ls_done  <= 1'b1;
              ls_err   <= !mem_ready;
              ls_rdata <= mem_ready ? load_data : 32'h0;
            end else begin
              if_done  <= 1'b1;
              if_err   <= !mem_ready;
              if_rdata <= mem_ready ? mem_rdata : 32'h0;
            end
          end
        end
        RESP:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed and randomized bench for mem_bus_arbiter against a rule-level model
// of alignment, lane selection, extension, latency and timeout.
module tb_mem_bus_arbiter;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, ls_req, ls_we, ls_unsigned;
  logic [31:0] if_addr, ls_addr, ls_wdata;
  logic [1:0]  ls_size;
  logic        if_done, if_err, ls_done, ls_err;
  logic [31:0] if_rdata, ls_rdata;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int passes = 0;
  int total  = 0;

  // memory responder state
  int          wait_target = 0;
  int          wait_cnt    = 0;
  int          req_cycles  = 0;
  bit          first_seen  = 0;
  bit          unstable    = 0;
  logic [31:0] seen_addr, seen_wdata;
  logic [3:0]  seen_be;
  logic        seen_we;

  mem_bus_arbiter #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done),
    .if_rdata(if_rdata), .if_err(if_err),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_size(ls_size),
    .ls_unsigned(ls_unsigned), .ls_wdata(ls_wdata), .ls_done(ls_done),
    .ls_rdata(ls_rdata), .ls_err(ls_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Answers after wait_target stall cycles; records what the bus looked like.
  always @(negedge clk) begin
    if (mem_req) begin
      req_cycles++;
      if (!first_seen) begin
        first_seen = 1;
        seen_addr = mem_addr; seen_be = mem_be; seen_we = mem_we; seen_wdata = mem_wdata;
      end else if (seen_addr !== mem_addr || seen_be !== mem_be ||
                   seen_we !== mem_we || seen_wdata !== mem_wdata) begin
        unstable = 1;
      end
      mem_ready = (wait_cnt == wait_target);
      wait_cnt++;
    end else begin
      wait_cnt  = 0;
      mem_ready = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, ".ctl"}, {24'h0, mem_req, mem_we, mem_be, 2'b00}, 32'h0);
    check({tag, ".flags"}, {28'h0, if_done, ls_done, if_err, ls_err}, 32'h0);
    check({tag, ".mem_addr"}, mem_addr, 32'h0);
    check({tag, ".mem_wdata"}, mem_wdata, 32'h0);
    check({tag, ".rdata"}, if_rdata | ls_rdata, 32'h0);
  endtask

  task automatic run_txn(input string tag, input bit is_ls, input bit we,
                         input logic [31:0] addr, input logic [1:0] size,
                         input bit uns, input logic [31:0] wdata,
                         input int waits, input logic [31:0] word);
    int          off, e_lat, e_reqc, done_cyc, own_cnt, oth_cnt;
    bit          mis, tmo;
    logic [31:0] e_be, e_wdata, e_rdata, v, g_rdata, g_err;
    logic [1:0]  sz;
    sz  = is_ls ? size : 2'b10;
    off = int'(addr % 4);
    mis = (sz == 3) || (sz == 2 && off != 0) || (sz == 1 && off % 2 != 0);
    tmo = !mis && waits >= TMO;
    e_be    = (sz == 0) ? (32'd1 << off) : (sz == 1) ? (32'd3 << (off & 2)) : 32'hF;
    e_wdata = (sz == 0) ? wdata[7:0] * 32'h01010101 :
              (sz == 1) ? wdata[15:0] * 32'h00010001 : wdata;
    v = word >> (8 * off);
    if (sz == 0) begin
      e_rdata = v & 32'hFF;
      if (!uns && v[7]) e_rdata = e_rdata + 32'hFFFFFF00;
    end else if (sz == 1) begin
      e_rdata = v & 32'hFFFF;
      if (!uns && v[15]) e_rdata = e_rdata + 32'hFFFF0000;
    end else e_rdata = v;
    if (mis || tmo) e_rdata = 32'h0;
    e_lat  = mis ? 1 : tmo ? TMO + 1 : waits + 2;
    e_reqc = mis ? 0 : tmo ? TMO : waits + 1;

    mem_rdata = word; wait_target = waits;
    req_cycles = 0; first_seen = 0; unstable = 0;
    @(negedge clk);
    if (is_ls) begin
      ls_req = 1; ls_we = we; ls_addr = addr; ls_size = size;
      ls_unsigned = uns; ls_wdata = wdata;
    end else begin
      if_req = 1; if_addr = addr;
    end
    done_cyc = -1; own_cnt = 0; oth_cnt = 0; g_rdata = 'x; g_err = 'x;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (is_ls ? ls_done : if_done) begin
        own_cnt++;
        if (done_cyc < 0) begin
          done_cyc = c;
          g_rdata  = is_ls ? ls_rdata : if_rdata;
          g_err    = {31'h0, is_ls ? ls_err : if_err};
        end
        ls_req = 0; if_req = 0;
      end
      if (is_ls ? if_done : ls_done) oth_cnt++;
      if (done_cyc >= 0 && c > done_cyc) break;
    end
    ls_req = 0; if_req = 0;
    check({tag, ".latency"}, 32'(done_cyc), 32'(e_lat));
    check({tag, ".err"}, g_err, {31'h0, mis || tmo});
    if (!(is_ls && we)) check({tag, ".rdata"}, g_rdata, e_rdata);
    check({tag, ".req_cycles"}, 32'(req_cycles), 32'(e_reqc));
    check({tag, ".done_pulses"}, {own_cnt[15:0], oth_cnt[15:0]}, {16'd1, 16'd0});
    if (!mis) begin
      check({tag, ".mem_addr"}, seen_addr, {addr[31:2], 2'b00});
      check({tag, ".mem_be"}, {28'h0, seen_be}, e_be);
      check({tag, ".mem_we"}, {31'h0, seen_we}, {31'h0, is_ls && we});
      if (is_ls && we) check({tag, ".mem_wdata"}, seen_wdata, e_wdata);
      check({tag, ".stable"}, {31'h0, unstable}, 32'h0);
    end
    $display("txn %s ls=%0d we=%0d addr=%h size=%0d uns=%0d waits=%0d lat=%0d err=%0h rdata=%h",
             tag, is_ls, we, addr, sz, uns, waits, done_cyc, g_err, g_rdata);
  endtask

  initial begin
    int ls_c, if_c, ls_n, if_n, stray;
    rst = 1; if_req = 0; ls_req = 0; ls_we = 0; ls_unsigned = 0;
    if_addr = 0; ls_addr = 0; ls_size = 0; ls_wdata = 0; mem_rdata = 0; mem_ready = 0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 0;

    run_txn("fetch",    0, 0, 32'h104,  2'b10, 0, 0, 0, 32'h00A00093);
    run_txn("lb_s",     1, 0, 32'h203,  2'b00, 0, 0, 3, 32'h80FF1234);
    run_txn("lbu",      1, 0, 32'h203,  2'b00, 1, 0, 3, 32'h80FF1234);
    run_txn("sh",       1, 1, 32'h1002, 2'b01, 0, 32'hDEADBEEF, 1, 0);
    run_txn("lw_mis",   1, 0, 32'h2001, 2'b10, 0, 0, 0, 32'h12345678);
    run_txn("timeout",  1, 0, 32'h3000, 2'b10, 0, 0, 255, 32'h1);
    run_txn("lh_neg",   1, 0, 32'h402,  2'b01, 0, 0, 0, 32'h9ABC0000);
    run_txn("sz11",     1, 0, 32'h500,  2'b11, 0, 0, 0, 32'h1);
    run_txn("if_mis",   0, 0, 32'h102,  2'b10, 0, 0, 0, 32'h1);

    // both requesters in the same cycle: LS wins, IF follows
    mem_rdata = 32'hCAFEF00D; wait_target = 0;
    @(negedge clk);
    ls_req = 1; ls_we = 0; ls_addr = 32'h300; ls_size = 2'b10; ls_unsigned = 0;
    if_req = 1; if_addr = 32'h400;
    ls_c = -1; if_c = -1; ls_n = 0; if_n = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (ls_done) begin ls_n++; if (ls_c < 0) ls_c = c; ls_req = 0; end
      if (if_done) begin if_n++; if (if_c < 0) if_c = c; if_req = 0; end
    end
    ls_req = 0; if_req = 0;
    check("both.ls_cycle", 32'(ls_c), 32'd2);
    check("both.if_cycle", 32'(if_c), 32'd5);
    check("both.pulses", {ls_n[15:0], if_n[15:0]}, {16'd1, 16'd1});
    $display("txn both ls_cycle=%0d if_cycle=%0d", ls_c, if_c);

    // reset in the middle of ACCESS
    wait_target = 255;
    @(negedge clk);
    ls_req = 1; ls_addr = 32'h600; ls_size = 2'b10; ls_we = 1; ls_wdata = 32'h55AA55AA;
    repeat (2) @(negedge clk);
    check("rstmid.in_access", {31'h0, mem_req}, 32'h1);
    rst = 1;
    @(negedge clk);
    check_outputs_zero("rstmid");
    rst = 0; ls_req = 0;
    stray = 0;
    repeat (8) begin @(negedge clk); if (ls_done || if_done || mem_req) stray++; end
    check("rstmid.no_done", 32'(stray), 32'd0);
    $display("txn rst_mid stray_events=%0d", stray);

    for (int i = 0; i < 40; i++) begin
      bit          is_ls;
      logic [31:0] a;
      is_ls = $urandom_range(0, 2) != 0;
      a = $urandom;
      if (!is_ls && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      run_txn($sformatf("rnd%0d", i), is_ls, 1'($urandom_range(0, 1)), a,
              2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom,
              int'($urandom_range(0, 5)), $urandom);
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
